// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - drains the TX FIFO and serializes each entry as an 8N1 UART frame

module uart_tx_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_read_en,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   baud_cnt;
    logic [CNT_W-1:0]   baud_cnt_nxt;
    logic [2:0]         bit_idx;
    logic [2:0]         bit_idx_nxt;
    logic [7:0]         shift_reg;
    logic [7:0]         shift_reg_nxt;
    logic               tx_nxt;
    logic               read_en_nxt;
    logic               done_nxt;
    logic               bit_end;

    // Only the low byte is sent; the rest of the FIFO word is deliberately dropped.
    logic               unused_fifo_bits;
    assign unused_fifo_bits = ^i_fifo_data;

    assign bit_end = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= S_IDLE;
            baud_cnt       <= '0;
            bit_idx        <= '0;
            shift_reg      <= '0;
            o_tx           <= 1'b1;
            o_fifo_read_en <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            state          <= state_nxt;
            baud_cnt       <= baud_cnt_nxt;
            bit_idx        <= bit_idx_nxt;
            shift_reg      <= shift_reg_nxt;
            o_tx           <= tx_nxt;
            o_fifo_read_en <= read_en_nxt;
            o_busy         <= (state_nxt != S_IDLE);
            o_done         <= done_nxt;
        end
    end

    // i_enable is only looked at in IDLE; once popped, a byte is always sent.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_enable && !i_fifo_empty) state_nxt = S_REQ;
            S_REQ:   state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_START;
            S_START: if (bit_end) state_nxt = S_DATA;
            S_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = S_STOP;
            S_STOP:  if (bit_end && bit_idx == 3'(STOP_BITS - 1)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tx_nxt        = o_tx;
        read_en_nxt   = 1'b0;
        done_nxt      = 1'b0;
        bit_idx_nxt   = bit_idx;
        shift_reg_nxt = shift_reg;
        baud_cnt_nxt  = '0;
        if (state == S_START || state == S_DATA || state == S_STOP) begin
            baud_cnt_nxt = bit_end ? '0 : baud_cnt + CNT_W'(1);
        end
        case (state)
            S_IDLE: begin
                tx_nxt      = 1'b1;
                read_en_nxt = (state_nxt == S_REQ);
            end
            S_REQ: begin
                tx_nxt = 1'b1;
            end
            S_WAIT: begin
                shift_reg_nxt = i_fifo_data[7:0];
                bit_idx_nxt   = '0;
                tx_nxt        = 1'b0;
            end
            S_START: begin
                if (bit_end) tx_nxt = shift_reg[0];
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        bit_idx_nxt = '0;
                        tx_nxt      = 1'b1;
                    end else begin
                        bit_idx_nxt   = bit_idx + 3'd1;
                        shift_reg_nxt = {1'b0, shift_reg[7:1]};
                        tx_nxt        = shift_reg[1];
                    end
                end
            end
            S_STOP: begin
                tx_nxt = 1'b1;
                // bit_idx is reused to count stop bits.
                if (bit_end) begin
                    if (bit_idx == 3'(STOP_BITS - 1)) begin
                        bit_idx_nxt = '0;
                        done_nxt    = 1'b1;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
            default: tx_nxt = 1'b1;
        endcase
    end

endmodule
